// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: shadows RF writes, waits for a completion write, then
// sweeps the shadow against an expected table. Optional macro: RFSB_MISMATCH_VEC_EN.
module regfile_scoreboard #(
  parameter int XLEN           = 32,
  parameter int NREGS          = 32,
  parameter int DONE_REG       = 8,
  parameter int DONE_VAL       = 1,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int AW = $clog2(NREGS),
  localparam int CW = $clog2(NREGS + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            exp_we,
  input  logic [AW-1:0]   exp_addr,
  input  logic [XLEN-1:0] exp_data,
  input  logic            exp_chk,
  input  logic            arm,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            timeout,
  output logic [CW-1:0]   err_count,
  output logic [AW-1:0]   first_err_idx,
  output logic [XLEN-1:0] first_err_got
`ifdef RFSB_MISMATCH_VEC_EN
  ,
  output logic [NREGS-1:0] mismatch_vec
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [AW-1:0] IDX_LAST    = AW'(NREGS - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SETTLE, S_CHECK, S_RESULT} state_t;

  state_t            state;
  logic [XLEN-1:0]   shadow  [NREGS];
  logic [XLEN-1:0]   exp_mem [NREGS];
  logic [NREGS-1:0]  mask;
  logic [TW-1:0]     wait_cnt;
  logic [SW-1:0]     settle_cnt;
  logic [AW-1:0]     idx;
  logic              issue_done;
  logic              vld_p1;
  logic              mism_p1;
  logic              last_p1;
  logic [AW-1:0]     idx_p1;
  logic [XLEN-1:0]   got_p1;
  logic              trigger;
  logic              load_ok;

  function automatic logic is_mismatch(input logic chk, input logic [XLEN-1:0] got,
                                       input logic [XLEN-1:0] want);
    return chk && (got != want);
  endfunction

  assign trigger = wr_en && (wr_addr == AW'(DONE_REG)) && (wr_data == XLEN'(DONE_VAL));
  assign load_ok = (state == S_IDLE) || (state == S_RESULT);

  assign busy = (state == S_WAIT) || (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_RESULT);
  assign pass = done && (err_count == '0) && !timeout;
  assign fail = done && ((err_count != '0) || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      for (int i = 0; i < NREGS; i++) shadow[i] <= '0;
      mask          <= '0;
      wait_cnt      <= '0;
      settle_cnt    <= '0;
      idx           <= '0;
      issue_done    <= 1'b0;
      vld_p1        <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_got <= '0;
      timeout       <= 1'b0;
`ifdef RFSB_MISMATCH_VEC_EN
      mismatch_vec  <= '0;
`endif
    end else begin
      if (wr_en && (wr_addr != '0)) shadow[wr_addr] <= wr_data;
      if (exp_we && load_ok) mask[exp_addr] <= exp_chk;

      case (state)
        S_IDLE, S_RESULT: begin
          if (arm) begin
            state         <= S_WAIT;
            wait_cnt      <= '0;
            settle_cnt    <= '0;
            idx           <= '0;
            issue_done    <= 1'b0;
            vld_p1        <= 1'b0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_got <= '0;
            timeout       <= 1'b0;
`ifdef RFSB_MISMATCH_VEC_EN
            mismatch_vec  <= '0;
`endif
          end
        end
        S_WAIT: begin
          // Trigger is tested first so it wins over a coincident timeout.
          if (trigger) begin
            state      <= S_SETTLE;
            settle_cnt <= '0;
          end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == TO_LAST)) begin
            state   <= S_RESULT;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= S_CHECK;
            idx        <= '0;
            issue_done <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt + SW'(1);
          end
        end
        S_CHECK: begin
          // Stage p0: issue one index per cycle into the compare register.
          vld_p1 <= !issue_done;
          if (!issue_done) begin
            if (idx == IDX_LAST) issue_done <= 1'b1;
            else                 idx        <= idx + AW'(1);
          end
          // Stage p1: accumulate the registered compare result.
          if (vld_p1) begin
            if (mism_p1) begin
              err_count <= err_count + CW'(1);
              if (err_count == '0) begin
                first_err_idx <= idx_p1;
                first_err_got <= got_p1;
              end
`ifdef RFSB_MISMATCH_VEC_EN
              mismatch_vec[idx_p1] <= 1'b1;
`endif
            end
            if (last_p1) begin
              state  <= S_RESULT;
              vld_p1 <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Expected table and compare datapath carry no reset.
  always_ff @(posedge clk) begin
    if (exp_we && load_ok) exp_mem[exp_addr] <= exp_data;
    if ((state == S_CHECK) && !issue_done) begin
      idx_p1  <= idx;
      got_p1  <= shadow[idx];
      last_p1 <= (idx == IDX_LAST);
      mism_p1 <= is_mismatch(mask[idx], shadow[idx], exp_mem[idx]);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (NREGS=32, SETTLE_CYCLES=1, TIMEOUT_CYCLES=50).
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  localparam int CW = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [XLEN-1:0] wr_data = '0;
  logic            exp_we = 1'b0;
  logic [AW-1:0]   exp_addr = '0;
  logic [XLEN-1:0] exp_data = '0;
  logic            exp_chk = 1'b0;
  logic            arm = 1'b0;
  logic            busy, done, pass, fail, timeout;
  logic [CW-1:0]   err_count;
  logic [AW-1:0]   first_err_idx;
  logic [XLEN-1:0] first_err_got;
`ifdef RFSB_MISMATCH_VEC_EN
  logic [NREGS-1:0] mismatch_vec;
`endif

  int vectors = 0;
  int miscompares = 0;

  regfile_scoreboard #(
    .XLEN(XLEN), .NREGS(NREGS), .DONE_REG(8), .DONE_VAL(1),
    .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_chk(exp_chk),
    .arm(arm),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .err_count(err_count), .first_err_idx(first_err_idx), .first_err_got(first_err_got)
`ifdef RFSB_MISMATCH_VEC_EN
    , .mismatch_vec(mismatch_vec)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = XLEN'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load(input int a, input int d, input logic c);
    exp_we = 1'b1; exp_addr = AW'(a); exp_data = XLEN'(d); exp_chk = c;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic load_table();
    load(8, 1, 1'b1); load(9, 2, 1'b1); load(18, 3, 1'b1);
    load(19, 4, 1'b1); load(20, 5, 1'b1); load(21, 6, 1'b1);
  endtask

  initial begin
    // Reset
    #3 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail", fail, 0);
    check("rst_timeout", timeout, 0);
    check("rst_err_count", err_count, 0);
    check("rst_first_idx", first_err_idx, 0);
    check("rst_first_got", first_err_got, 0);
    rst_n = 1'b1;
    tick();

    // 1: all matching, exact latency
    load_table();
    pulse_arm();
    check("s1_busy_wait", busy, 1);
    wr(18, 3); wr(19, 4); wr(20, 5); wr(21, 6); wr(9, 2);
    wr(8, 1);
    repeat (33) tick();
    check("s1_done_e33", done, 0);
    tick();
    check("s1_done_e34", done, 1);
    check("s1_pass", pass, 1);
    check("s1_fail", fail, 0);
    check("s1_err_count", err_count, 0);
    check("s1_busy", busy, 0);

    // 2: single mismatch at x20
    pulse_arm();
    check("s2_cleared", done, 0);
    wr(20, 7);
    wr(8, 1);
    wait_done("s2_done");
    check("s2_fail", fail, 1);
    check("s2_pass", pass, 0);
    check("s2_err_count", err_count, 1);
    check("s2_first_idx", first_err_idx, 20);
    check("s2_first_got", first_err_got, 7);
`ifdef RFSB_MISMATCH_VEC_EN
    check("s2_mismatch_vec", mismatch_vec, 64'h0010_0000);
`endif

    // 3: x0 writes ignored, wrong done value does not trigger
    load(0, 0, 1'b1);
    pulse_arm();
    wr(20, 5);
    wr(0, 5);
    wr(8, 2);
    repeat (3) tick();
    check("s3_busy_no_trig", busy, 1);
    check("s3_done_no_trig", done, 0);
    wr(8, 1);
    wait_done("s3_done");
    check("s3_pass", pass, 1);
    check("s3_err_count", err_count, 0);

    // 4a: timeout exactly 50 cycles after WAIT entry
    pulse_arm();
    repeat (49) tick();
    check("s4_done_49", done, 0);
    check("s4_busy_49", busy, 1);
    tick();
    check("s4_done_50", done, 1);
    check("s4_timeout", timeout, 1);
    check("s4_fail", fail, 1);
    check("s4_pass", pass, 0);
    check("s4_err_count", err_count, 0);

    // 4b: trigger on the timeout cycle wins
    pulse_arm();
    check("s4b_timeout_clr", timeout, 0);
    repeat (49) tick();
    wr(8, 1);
    check("s4b_busy", busy, 1);
    check("s4b_no_timeout", timeout, 0);
    wait_done("s4b_done");
    check("s4b_pass", pass, 1);
    check("s4b_timeout", timeout, 0);

    // 5: reset at CHECK idx=10
    pulse_arm();
    wr(8, 1);
    repeat (11) tick();
    check("s5_busy_check", busy, 1);
    rst_n = 1'b0;
    #1;
    check("s5_rst_busy", busy, 0);
    check("s5_rst_done", done, 0);
    check("s5_rst_pass", pass, 0);
    check("s5_rst_fail", fail, 0);
    check("s5_rst_err_count", err_count, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    check("s5_no_done", done, 0);
    check("s5_idle", busy, 0);
    // Shadow was cleared: only x8 written, so x9,x18..x21 read back as 0
    load_table();
    pulse_arm();
    wr(8, 1);
    wait_done("s5_zero_done");
    check("s5_zero_err_count", err_count, 5);
    check("s5_zero_first_idx", first_err_idx, 9);
    check("s5_zero_first_got", first_err_got, 0);
    // Rerun scenario 1
    pulse_arm();
    wr(18, 3); wr(19, 4); wr(20, 5); wr(21, 6); wr(9, 2);
    wr(8, 1);
    wait_done("s5_rerun_done");
    check("s5_rerun_pass", pass, 1);
    check("s5_rerun_err_count", err_count, 0);

    // 6: re-arm from RESULT, x9=9; exp_we in CHECK is ignored
    pulse_arm();
    wr(9, 9);
    wr(8, 1);
    tick();
    load(9, 9, 1'b1);
    wait_done("s6_done");
    check("s6_err_count", err_count, 1);
    check("s6_first_idx", first_err_idx, 9);
    check("s6_first_got", first_err_got, 9);
    check("s6_fail", fail, 1);
    // The same load in RESULT is accepted
    load(9, 9, 1'b1);
    pulse_arm();
    wr(8, 1);
    wait_done("s6_reload_done");
    check("s6_reload_pass", pass, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
